// File: rtl/alu_seq.sv
// Registered ALU with shift-add multiplier: single-cycle ops valid 1 clk after accept, MUL after bits+1.
// Accepts only in IDLE; result and flags hold in DONE until ready_i.
module alu_seq #(
    parameter int bits = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      op_i,
    input  logic [bits-1:0] bus_a_i,
    input  logic [bits-1:0] bus_b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [bits-1:0] bus_s_o,
    output logic            flag_n_o,
    output logic            flag_z_o,
    output logic            flag_c_o,
    output logic            flag_v_o,
    output logic            err_o
);

    localparam int SH_W = $clog2(bits);
    localparam logic [bits-1:0] WIDTH_V = bits'(bits);
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(bits - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [bits-1:0]   mcand_q, mcand_d;
    logic [2*bits-1:0] prod_q, prod_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [bits-1:0]   s_q, s_d;
    logic              n_q, n_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic              v_q, v_d;
    logic              err_q, err_d;

    logic [bits:0]     add_w;
    logic [bits:0]     sub_w;
    logic [bits:0]     shl_w;
    logic [bits:0]     shr_w;
    logic [SH_W-1:0]   shamt;
    logic              b_lt_w;
    logic              b_eq_w;

    logic [bits-1:0]   alu_s;
    logic [bits-1:0]   alu_nz;
    logic              alu_c;
    logic              alu_v;
    logic              alu_err;

    logic [bits:0]     mul_sum;
    logic [2*bits-1:0] mul_next;

    assign add_w  = {1'b0, bus_a_i} + {1'b0, bus_b_i};
    assign sub_w  = {1'b0, bus_a_i} + {1'b0, ~bus_b_i} + {{bits{1'b0}}, 1'b1};
    assign b_lt_w = (bus_b_i < WIDTH_V);
    assign b_eq_w = (bus_b_i == WIDTH_V);
    assign shamt  = bus_b_i[SH_W-1:0];
    // Extra guard bit on each shifter catches the last bit shifted out.
    assign shl_w  = {1'b0, bus_a_i} << shamt;
    assign shr_w  = {bus_a_i, 1'b0} >> shamt;

    // Multiplier: add A into the high half when the current LSB is set, then shift right.
    assign mul_sum  = {1'b0, prod_q[2*bits-1:bits]} + (prod_q[0] ? {1'b0, mcand_q} : {(bits+1){1'b0}});
    assign mul_next = {mul_sum, prod_q[bits-1:1]};

    always_comb begin
        alu_s   = '0;
        alu_nz  = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_s = add_w[bits-1:0];
                alu_c = add_w[bits];
                alu_v = (bus_a_i[bits-1] == bus_b_i[bits-1]) && (add_w[bits-1] != bus_a_i[bits-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_s = (op_i == OP_CMP) ? bus_a_i : sub_w[bits-1:0];
                alu_c = sub_w[bits];
                alu_v = (bus_a_i[bits-1] != bus_b_i[bits-1]) && (sub_w[bits-1] != bus_a_i[bits-1]);
            end
            OP_SHL: begin
                if (b_lt_w) begin
                    alu_s = shl_w[bits-1:0];
                    alu_c = shl_w[bits];
                end else begin
                    alu_c = b_eq_w & bus_a_i[0];
                end
            end
            OP_SHR: begin
                if (b_lt_w) begin
                    alu_s = shr_w[bits:1];
                    alu_c = shr_w[0];
                end else begin
                    alu_c = b_eq_w & bus_a_i[bits-1];
                end
            end
            OP_OR:   alu_s = bus_a_i | bus_b_i;
            OP_AND:  alu_s = bus_a_i & bus_b_i;
            OP_XOR:  alu_s = bus_a_i ^ bus_b_i;
            OP_NOT:  alu_s = ~bus_a_i;
            OP_MUL:  alu_s = '0;
            default: alu_err = 1'b1;
        endcase
        // CMP reports flags of the difference while passing A through.
        alu_nz = (op_i == OP_CMP) ? sub_w[bits-1:0] : alu_s;
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        n_d     = n_q;
        z_d     = z_q;
        c_d     = c_q;
        v_d     = v_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (op_i == OP_MUL) begin
                        state_d = ST_MUL;
                        mcand_d = bus_a_i;
                        prod_d  = {{bits{1'b0}}, bus_b_i};
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        s_d     = alu_s;
                        n_d     = alu_nz[bits-1];
                        z_d     = ~|alu_nz;
                        c_d     = alu_c;
                        v_d     = alu_v;
                        err_d   = alu_err;
                    end
                end
            end
            ST_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + SH_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    s_d     = mul_next[bits-1:0];
                    n_d     = mul_next[bits-1];
                    z_d     = ~|mul_next[bits-1:0];
                    c_d     = 1'b0;
                    v_d     = |mul_next[2*bits-1:bits];
                    err_d   = 1'b0;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            z_q     <= z_d;
            c_q     <= c_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign bus_s_o  = s_q;
    assign flag_n_o = n_q;
    assign flag_z_o = z_q;
    assign flag_c_o = c_q;
    assign flag_v_o = v_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq (bits=8) against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [3:0]   op_i;
    logic [W-1:0] bus_a_i;
    logic [W-1:0] bus_b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] bus_s_o;
    logic         flag_n_o;
    logic         flag_z_o;
    logic         flag_c_o;
    logic         flag_v_o;
    logic         err_o;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.bits(W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .bus_a_i  (bus_a_i),
        .bus_b_i  (bus_b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .bus_s_o  (bus_s_o),
        .flag_n_o (flag_n_o),
        .flag_z_o (flag_z_o),
        .flag_c_o (flag_c_o),
        .flag_v_o (flag_v_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] dut_vec();
        return {err_o, flag_n_o, flag_z_o, flag_c_o, flag_v_o, bus_s_o};
    endfunction

    // Reference: {err, n, z, c, v, s} from plain integer arithmetic.
    function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, r, sr, t;
        logic [7:0] s, nz;
        logic c, v, e;
        ia = a; ib = b;
        sa = $signed(a); sb = $signed(b);
        r = 0; t = 0; s = 0; c = 0; v = 0; e = 0;
        case (op)
            4'd0: begin r = ia + ib; s = r[7:0]; c = (r > 255);
                        sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd1, 4'd9: begin r = ia - ib; s = (op == 4'd9) ? a : r[7:0]; c = (ia >= ib);
                        sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd2: begin
                if (ib < 8) begin r = ia << ib; s = r[7:0]; end
                if (ib >= 1 && ib <= 8) begin t = ia >> (8 - ib); c = t[0]; end
            end
            4'd3: begin
                if (ib < 8) begin r = ia >> ib; s = r[7:0]; end
                if (ib >= 1 && ib <= 8) begin t = ia >> (ib - 1); c = t[0]; end
            end
            4'd4: s = a | b;
            4'd5: s = a & b;
            4'd6: s = a ^ b;
            4'd7: s = ~a;
            4'd8: begin r = ia * ib; s = r[7:0]; v = (r > 255); end
            default: e = 1;
        endcase
        nz = (op == 4'd9) ? r[7:0] : s;
        return {e, nz[7], (nz == 8'd0), c, v, s};
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int stall);
        int lat, waited;
        logic [12:0] exp;
        exp = model(op, a, b);
        waited = 0;
        while (!ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        check("ready_before_op", ready_o, 1);
        op_i = op; bus_a_i = a; bus_b_i = b; valid_i = 1'b1; ready_i = 1'b0;
        @(negedge clk_i);
        op_i = 4'($urandom); bus_a_i = 8'($urandom); bus_b_i = 8'($urandom);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 40) begin
            check("busy_ready", ready_o, 0);
            valid_i = 1'($urandom);
            @(negedge clk_i);
            lat++;
        end
        check("latency", lat, (op == 4'd8) ? 9 : 1);
        check("result", dut_vec(), exp);
        for (int k = 0; k < stall; k++) begin
            valid_i = 1'b1; op_i = 4'($urandom); bus_a_i = 8'($urandom); bus_b_i = 8'($urandom);
            @(negedge clk_i);
            check("stall_valid", valid_o, 1);
            check("stall_ready", ready_o, 0);
            check("stall_result", dut_vec(), exp);
        end
        valid_i = 1'b0; ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("release_valid", valid_o, 0);
        check("release_ready", ready_o, 1);
    endtask

    initial begin
        int op_r;
        logic [7:0] a_r, b_r;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        op_i = 4'd0; bus_a_i = '0; bus_b_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_ready", ready_o, 1);
        check("reset_valid", valid_o, 0);
        check("reset_outputs", dut_vec(), 0);

        do_op(4'd0, 8'hFF, 8'h01, 0);
        do_op(4'd1, 8'h80, 8'h01, 0);
        do_op(4'd9, 8'h03, 8'h05, 1);
        do_op(4'd8, 8'h10, 8'h11, 0);
        do_op(4'd2, 8'h81, 8'h01, 0);
        do_op(4'd3, 8'h81, 8'h09, 0);
        do_op(4'd2, 8'h81, 8'h08, 0);
        do_op(4'd3, 8'h80, 8'h08, 0);
        do_op(4'd2, 8'h81, 8'h00, 0);
        do_op(4'd6, 8'hA5, 8'h5A, 3);
        do_op(4'd8, 8'hFF, 8'hFF, 3);
        do_op(4'd0, 8'h7F, 8'h01, 0);

        // Reset partway through a multiply: nothing may be emitted for it.
        op_i = 4'd8; bus_a_i = 8'h37; bus_b_i = 8'h59; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midmul_rst_valid", valid_o, 0);
        check("midmul_rst_ready", ready_o, 1);
        check("midmul_rst_outputs", dut_vec(), 0);
        repeat (10) @(negedge clk_i);
        check("midmul_no_emit", valid_o, 0);
        do_op(4'hC, 8'h12, 8'h34, 0);

        for (int i = 0; i < 250; i++) begin
            op_r = $urandom_range(0, 15);
            a_r = 8'($urandom);
            b_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            do_op(4'(op_r), a_r, b_r, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
